// File: rtl/sal_bank_timing_ctrl_if.sv
// Scheduler-to-bank bus: timing values, command grants, legality and bank status.
// SAL_BANK_AUTO_PRE_EN adds the rd_ap/wr_ap auto-precharge qualifiers.
interface sal_bank_timing_ctrl_if #(
    parameter int unsigned TIMER_W = 8,
    parameter int unsigned ROW_W   = 14
);
    logic [TIMER_W-1:0] t_rcd;
    logic [TIMER_W-1:0] t_rp;
    logic [TIMER_W-1:0] t_ras;
    logic [TIMER_W-1:0] t_rfc;
    logic [TIMER_W-1:0] t_rtp;
    logic [TIMER_W-1:0] t_wtp;
    logic               act_gnt;
    logic [ROW_W-1:0]   act_row;
    logic               rd_gnt;
    logic               wr_gnt;
    logic               pre_gnt;
    logic               ref_gnt;
`ifdef SAL_BANK_AUTO_PRE_EN
    logic               rd_ap;
    logic               wr_ap;
`endif
    logic               act_ok;
    logic               rd_ok;
    logic               wr_ok;
    logic               pre_ok;
    logic               ref_ok;
    logic               row_open;
    logic [ROW_W-1:0]   cur_row;
    logic [2:0]         bank_state;
    logic               cmd_err;

    modport master (
`ifdef SAL_BANK_AUTO_PRE_EN
        output rd_ap, wr_ap,
`endif
        output t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp,
        output act_gnt, act_row, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
        input  act_ok, rd_ok, wr_ok, pre_ok, ref_ok, row_open, cur_row, bank_state, cmd_err
    );

    modport slave (
`ifdef SAL_BANK_AUTO_PRE_EN
        input  rd_ap, wr_ap,
`endif
        input  t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp,
        input  act_gnt, act_row, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
        output act_ok, rd_ok, wr_ok, pre_ok, ref_ok, row_open, cur_row, bank_state, cmd_err
    );
endinterface

// File: rtl/sal_bank_timing_ctrl.sv
// Per-bank DDR2 timing tracker: bank FSM, tRCD/tRAS/tRP/tRFC/tRTP/tWTP timers, legality flags.
// Optional SAL_BANK_AUTO_PRE_EN: RD/WR with auto-precharge closes the row on its own.
module sal_bank_timing_ctrl #(
    parameter int unsigned TIMER_W = 8,
    parameter int unsigned ROW_W   = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    sal_bank_timing_ctrl_if.slave bus
);
    typedef logic [TIMER_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ACTIVATING  = 3'd1,
        ACTIVE      = 3'd2,
        PRECHARGING = 3'd3,
        REFRESHING  = 3'd4
    } state_t;

    state_t           state, state_n;
    cnt_t             phase_cnt, phase_n;
    cnt_t             ras_cnt, ras_n;
    cnt_t             rw_cnt, rw_n;
    logic [ROW_W-1:0] row_n;
    logic [2:0]       n_gnt;
    logic             err_n;
    logic             act_acc, rd_acc, wr_acc, pre_acc, ref_acc;
    logic             ap_blk;
`ifdef SAL_BANK_AUTO_PRE_EN
    logic             ap_pending, ap_n;
`endif

    // Counter holds cycles-remaining-minus-one, so expiry lines up with cycle C+t.
    function automatic cnt_t load_val(input cnt_t t);
        return (t > TIMER_W'(1)) ? t - TIMER_W'(1) : '0;
    endfunction

    function automatic cnt_t dec(input cnt_t c);
        return (c != '0) ? c - TIMER_W'(1) : '0;
    endfunction

    function automatic cnt_t max_c(input cnt_t a, input cnt_t b);
        return (a > b) ? a : b;
    endfunction

    // Illegal or conflicting grants are dropped as a whole.
    always_comb begin
        n_gnt   = 3'(bus.act_gnt) + 3'(bus.rd_gnt) + 3'(bus.wr_gnt) + 3'(bus.pre_gnt) + 3'(bus.ref_gnt);
        err_n   = (n_gnt > 3'd1) ||
                  (bus.act_gnt && !bus.act_ok) || (bus.rd_gnt  && !bus.rd_ok) ||
                  (bus.wr_gnt  && !bus.wr_ok)  || (bus.pre_gnt && !bus.pre_ok) ||
                  (bus.ref_gnt && !bus.ref_ok);
        act_acc = bus.act_gnt && !err_n;
        rd_acc  = bus.rd_gnt  && !err_n;
        wr_acc  = bus.wr_gnt  && !err_n;
        pre_acc = bus.pre_gnt && !err_n;
        ref_acc = bus.ref_gnt && !err_n;
    end

    always_comb begin
        state_n = state;
        phase_n = dec(phase_cnt);
        ras_n   = dec(ras_cnt);
        rw_n    = dec(rw_cnt);
        row_n   = bus.cur_row;
`ifdef SAL_BANK_AUTO_PRE_EN
        ap_n    = ap_pending;
`endif
        case (state)
            IDLE: begin
                if (act_acc) begin
                    row_n   = bus.act_row;
                    ras_n   = load_val(bus.t_ras);
                    phase_n = load_val(bus.t_rcd);
                    state_n = (phase_n == '0) ? ACTIVE : ACTIVATING;
                end else if (ref_acc) begin
                    phase_n = load_val(bus.t_rfc);
                    state_n = (phase_n == '0) ? IDLE : REFRESHING;
                end
            end
            ACTIVATING: begin
                if (phase_n == '0) state_n = ACTIVE;
            end
            ACTIVE: begin
                if (rd_acc) rw_n = max_c(rw_n, load_val(bus.t_rtp));
                if (wr_acc) rw_n = max_c(rw_n, load_val(bus.t_wtp));
                if (pre_acc) begin
                    phase_n = load_val(bus.t_rp);
                    state_n = (phase_n == '0) ? IDLE : PRECHARGING;
                end
`ifdef SAL_BANK_AUTO_PRE_EN
                if ((rd_acc && bus.rd_ap) || (wr_acc && bus.wr_ap)) ap_n = 1'b1;
                // Self-precharge is visible in the first cycle PRE would be legal, so tRP counts from there.
                if (ap_n && (ras_n == '0) && (rw_n == '0)) begin
                    state_n = PRECHARGING;
                    phase_n = load_val(bus.t_rp) + TIMER_W'(1);
                    ap_n    = 1'b0;
                end
`endif
            end
            PRECHARGING, REFRESHING: begin
                if (phase_n == '0) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef SAL_BANK_AUTO_PRE_EN
    assign ap_blk = ap_n;
`else
    assign ap_blk = 1'b0;
`endif

    // State, timers and outputs, all decoded from next-state values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            phase_cnt      <= '0;
            ras_cnt        <= '0;
            rw_cnt         <= '0;
            bus.act_ok     <= 1'b1;
            bus.ref_ok     <= 1'b1;
            bus.rd_ok      <= 1'b0;
            bus.wr_ok      <= 1'b0;
            bus.pre_ok     <= 1'b0;
            bus.row_open   <= 1'b0;
            bus.cur_row    <= '0;
            bus.bank_state <= 3'd0;
            bus.cmd_err    <= 1'b0;
`ifdef SAL_BANK_AUTO_PRE_EN
            ap_pending     <= 1'b0;
`endif
        end else begin
            state          <= state_n;
            phase_cnt      <= phase_n;
            ras_cnt        <= ras_n;
            rw_cnt         <= rw_n;
            bus.act_ok     <= (state_n == IDLE);
            bus.ref_ok     <= (state_n == IDLE);
            bus.rd_ok      <= (state_n == ACTIVE) && !ap_blk;
            bus.wr_ok      <= (state_n == ACTIVE) && !ap_blk;
            bus.pre_ok     <= (state_n == ACTIVE) && (ras_n == '0) && (rw_n == '0) && !ap_blk;
            bus.row_open   <= (state_n == ACTIVATING) || (state_n == ACTIVE);
            bus.cur_row    <= row_n;
            bus.bank_state <= state_n;
            bus.cmd_err    <= err_n;
`ifdef SAL_BANK_AUTO_PRE_EN
            ap_pending     <= ap_n;
`endif
        end
    end
endmodule

// File: tb/tb_sal_bank_timing_ctrl.sv
// Scoreboard bench for sal_bank_timing_ctrl: timestamp-based bank model, directed and random grants.
module tb_sal_bank_timing_ctrl;
    localparam int unsigned TW = 8;
    localparam int unsigned RW = 14;

    typedef struct packed {
        logic [2:0]    st;
        logic          act_ok, rd_ok, wr_ok, pre_ok, ref_ok, row_open;
        logic [RW-1:0] row;
        logic          err;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sal_bank_timing_ctrl_if #(.TIMER_W(TW), .ROW_W(RW)) bus ();
    sal_bank_timing_ctrl #(.TIMER_W(TW), .ROW_W(RW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Model: absolute cycle numbers at which each rule releases.
    bit            m_open, m_ap, m_err;
    int            m_active_at, m_ras_at, m_rw_at, m_idle_at, m_busy;
    logic [RW-1:0] m_row;
    logic [TW-1:0] v_rcd, v_rp, v_ras, v_rfc, v_rtp, v_wtp;
    int            base, first_act, first_rd, first_pre, first_pc;

    function automatic int eff(input logic [TW-1:0] t);
        return (t == '0) ? 1 : int'(t);
    endfunction

    function automatic void m_reset();
        m_open = 0; m_ap = 0; m_err = 0; m_busy = 0; m_row = '0;
        m_active_at = 0; m_ras_at = 0; m_rw_at = 0; m_idle_at = 0;
    endfunction

    function automatic obs_t model_expect(input int k);
        obs_t e;
        int   st;
        if (m_ap && m_open && k >= m_active_at && k >= m_ras_at && k >= m_rw_at) begin
            m_open = 0; m_ap = 0; m_busy = 3; m_idle_at = k + eff(bus.t_rp);
        end
        st = m_open ? ((k < m_active_at) ? 1 : 2) : ((k < m_idle_at) ? m_busy : 0);
        e.st       = 3'(st);
        e.act_ok   = (st == 0);
        e.ref_ok   = (st == 0);
        e.rd_ok    = (st == 2) && !m_ap;
        e.wr_ok    = (st == 2) && !m_ap;
        e.pre_ok   = (st == 2) && (k >= m_ras_at) && (k >= m_rw_at) && !m_ap;
        e.row_open = (st == 1) || (st == 2);
        e.row      = m_row;
        e.err      = m_err;
        return e;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.st = bus.bank_state; o.act_ok = bus.act_ok; o.rd_ok = bus.rd_ok; o.wr_ok = bus.wr_ok;
        o.pre_ok = bus.pre_ok; o.ref_ok = bus.ref_ok; o.row_open = bus.row_open;
        o.row = bus.cur_row; o.err = bus.cmd_err;
        return o;
    endfunction

    function automatic void chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endfunction

    // mode 0: given grants, 1: one random legal grant, 2: random grant bits.
    task automatic step(input int mode, input bit a, input bit r, input bit w, input bit p, input bit f,
                        input logic [RW-1:0] row, input bit ap, input bit do_rst);
        obs_t e;
        int   n, pick;
        bit   bad;
        int   c[$];
        @(posedge clk); #1;
        rst = do_rst;
        if (do_rst) m_reset();
        e = model_expect(cyc);
        exp_q.push_back(e);
        if (cyc > base) begin
            if (bus.act_ok && first_act < 0) first_act = cyc - base;
            if (bus.rd_ok && first_rd < 0) first_rd = cyc - base;
            if (bus.pre_ok && first_pre < 0) first_pre = cyc - base;
            if (bus.bank_state == 3'd3 && first_pc < 0) first_pc = cyc - base;
        end
        if (mode == 1) begin
            {a, r, w, p, f} = 5'b0;
            if (e.act_ok) c.push_back(0);
            if (e.rd_ok)  c.push_back(1);
            if (e.wr_ok)  c.push_back(2);
            if (e.pre_ok) c.push_back(3);
            if (e.ref_ok && $urandom_range(0, 3) == 0) c.push_back(4);
            if (c.size() > 0) begin
                pick = c[$urandom_range(0, c.size() - 1)];
                a = (pick == 0); r = (pick == 1); w = (pick == 2); p = (pick == 3); f = (pick == 4);
            end
            row = RW'($urandom);
            ap  = ($urandom_range(0, 3) == 0);
        end else if (mode == 2) begin
            {a, r, w, p, f} = 5'($urandom);
        end
        if (do_rst) {a, r, w, p, f} = 5'b0;
        bus.t_rcd = v_rcd; bus.t_rp = v_rp; bus.t_ras = v_ras;
        bus.t_rfc = v_rfc; bus.t_rtp = v_rtp; bus.t_wtp = v_wtp;
        bus.act_gnt = a; bus.rd_gnt = r; bus.wr_gnt = w; bus.pre_gnt = p; bus.ref_gnt = f;
        bus.act_row = row;
`ifdef SAL_BANK_AUTO_PRE_EN
        bus.rd_ap = ap && r;
        bus.wr_ap = ap && w;
`endif
        n   = int'(a) + int'(r) + int'(w) + int'(p) + int'(f);
        bad = (a && !e.act_ok) || (r && !e.rd_ok) || (w && !e.wr_ok) || (p && !e.pre_ok) || (f && !e.ref_ok);
        m_err = !do_rst && (n > 1 || bad);
        if (!do_rst && !m_err && n == 1) begin
            if (a) begin
                m_open = 1; m_row = row;
                m_active_at = cyc + eff(v_rcd); m_ras_at = cyc + eff(v_ras);
            end
            if (f) begin m_busy = 4; m_idle_at = cyc + eff(v_rfc); end
            if (p) begin m_open = 0; m_busy = 3; m_idle_at = cyc + eff(v_rp); end
            if (r && cyc + eff(v_rtp) > m_rw_at) m_rw_at = cyc + eff(v_rtp);
            if (w && cyc + eff(v_wtp) > m_rw_at) m_rw_at = cyc + eff(v_wtp);
`ifdef SAL_BANK_AUTO_PRE_EN
            if ((r || w) && ap) m_ap = 1;
`endif
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, '0, 0, 0);
    endtask

    task automatic rst_pulse();
        step(0, 0, 0, 0, 0, 0, '0, 0, 1);
        idle(1);
    endtask

    task automatic mark();
        base = cyc; first_act = -1; first_rd = -1; first_pre = -1; first_pc = -1;
    endtask

    task automatic std_timing();
        v_rcd = 8'd3; v_ras = 8'd8; v_rp = 8'd3; v_rfc = 8'd10; v_rtp = 8'd2; v_wtp = 8'd5;
    endtask

    always @(negedge clk) begin : monitor
        obs_t e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = dut_obs();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL scoreboard cyc=%0d got=%h required=%h (st,act,rd,wr,pre,ref,open,row,err)",
                         cyc - 1, g, e);
            end
        end
    end

    initial begin
        bus.act_gnt = 0; bus.rd_gnt = 0; bus.wr_gnt = 0; bus.pre_gnt = 0; bus.ref_gnt = 0;
        bus.act_row = '0;
`ifdef SAL_BANK_AUTO_PRE_EN
        bus.rd_ap = 0; bus.wr_ap = 0;
`endif
        std_timing();
        m_reset();
        mark();
        step(0, 0, 0, 0, 0, 0, '0, 0, 1);
        step(0, 0, 0, 0, 0, 0, '0, 0, 1);
        idle(2);

        // reset in the middle of ACTIVATING
        step(0, 1, 0, 0, 0, 0, 14'h0AB, 0, 0);
        idle(1);
        rst_pulse();
        idle(1);

        // ACT row 0x1A5, then close it
        mark();
        step(0, 1, 0, 0, 0, 0, 14'h1A5, 0, 0);
        idle(8);
        chk("act_to_rd_first", first_rd, 3);
        step(0, 0, 0, 0, 1, 0, '0, 0, 0);
        idle(3);

        // tRAS dominates a single RD
        mark();
        step(0, 1, 0, 0, 0, 0, 14'h0011, 0, 0);
        idle(2);
        step(0, 0, 1, 0, 0, 0, '0, 0, 0);
        idle(5);
        chk("rd_pre_first", first_pre, 8);
        step(0, 0, 0, 0, 1, 0, '0, 0, 0);
        idle(3);

        // late WR extends the precharge block
        mark();
        step(0, 1, 0, 0, 0, 0, 14'h0022, 0, 0);
        idle(2);
        step(0, 0, 1, 0, 0, 0, '0, 0, 0);
        idle(2);
        step(0, 0, 0, 1, 0, 0, '0, 0, 0);
        idle(5);
        chk("wr_pre_first", first_pre, 11);
        step(0, 0, 0, 0, 1, 0, '0, 0, 0);
        idle(3);

        // PRE -> tRP -> IDLE
        mark();
        step(0, 1, 0, 0, 0, 0, 14'h0033, 0, 0);
        idle(7);
        step(0, 0, 0, 0, 1, 0, '0, 0, 0);
        idle(4);
        chk("pre_act_first", first_act, 11);

        // REF -> tRFC -> IDLE
        mark();
        step(0, 0, 0, 0, 0, 1, '0, 0, 0);
        idle(11);
        chk("ref_act_first", first_act, 10);

        // illegal and conflicting grants
        step(0, 0, 1, 0, 0, 0, '0, 0, 0);
        idle(1);
        step(0, 1, 0, 0, 0, 1, 14'h0044, 0, 0);
        idle(1);
        step(0, 1, 0, 0, 0, 0, 14'h0055, 0, 0);
        idle(4);
        step(0, 0, 0, 0, 1, 0, '0, 0, 0);
        idle(1);
        rst_pulse();

        // zero timing value behaves as one
        v_rcd = 8'd0;
        mark();
        step(0, 1, 0, 0, 0, 0, 14'h0066, 0, 0);
        idle(2);
        chk("rcd_zero_rd_first", first_rd, 1);
        std_timing();
        rst_pulse();

`ifdef SAL_BANK_AUTO_PRE_EN
        // read with auto-precharge
        mark();
        step(0, 1, 0, 0, 0, 0, 14'h0077, 0, 0);
        idle(2);
        step(0, 0, 1, 0, 0, 0, '0, 1, 0);
        idle(9);
        chk("ap_prechg_first", first_pc, 8);
        chk("ap_act_first", first_act, 11);
`endif

        // randomized traffic with random timing values
        for (int i = 0; i < 2000; i++) begin
            int sel;
            if (i % 128 == 0) begin
                v_rcd = 8'($urandom_range(0, 5)); v_ras = 8'($urandom_range(0, 10));
                v_rp  = 8'($urandom_range(0, 5)); v_rfc = 8'($urandom_range(0, 12));
                v_rtp = 8'($urandom_range(0, 4)); v_wtp = 8'($urandom_range(0, 7));
            end
            sel = $urandom_range(0, 399);
            if (sel == 0)       step(0, 0, 0, 0, 0, 0, '0, 0, 1);
            else if (sel < 10)  step(2, 0, 0, 0, 0, 0, RW'($urandom), 0, 0);
            else if (sel < 140) step(1, 0, 0, 0, 0, 0, '0, 0, 0);
            else                idle(1);
        end
        idle(4);

        @(posedge clk); #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
